// File: rtl/tristate_bus_pkg.sv
// Shared definitions for the tristate bus arbiter.
// Contents:
//   WIDTH     - data width of each tristate driver that the enables control
//   state_e   - arbiter FSM states (IDLE, GRANT, TURN)
//   wrap_add  - modular index addition for round-robin index arithmetic
package tristate_bus_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // (a + b) mod n, valid for a < n and b < n so a single subtract suffices
  function automatic int wrap_add(input int a, input int b, input int n);
    int sum;
    sum = a + b;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin priority select.
// Ports:
//   req   [N-1:0]     request vector
//   ptr   [IDX_W-1:0] index where the upward search begins
//   found             any request bit set
//   idx   [IDX_W-1:0] first set request at or above ptr, wrapping N-1 -> 0
module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;

  // Rotate requests so ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[N-1:0];
    found = |req;
    idx   = {IDX_W{1'b0}};
    // Scan downward so the lowest rotated position is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      idx = rot_s[i] ? IDX_W'(wrap_add(int'(ptr), i, N)) : idx;
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Output-enable controller for N drivers sharing one tristate net.
// Round-robin grant, bounded hold per ownership, and all-off turnaround
// cycles between owners so at most one driver is ever enabled.
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req   [N]   per-driver bus request (level)
//   done  [N]   early release pulse, honoured only from the current owner
//   en    [N]   registered one-hot-or-zero driver enables
//   owner       index of the current owner (meaningful while busy)
//   busy        high while any en bit is high
//   turnaround  high during the all-off gap between owners
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N           = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 turnaround
);

  localparam int IDX_W  = $clog2(N);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURN_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [TURN_W-1:0] TURN_LIMIT = TURN_W'(TURN_CYCLES);
  localparam logic [TURN_W-1:0] TURN_ONE   = TURN_W'(1);

  state_e            state_r;
  logic [HOLD_W-1:0] hold_r;
  logic [TURN_W-1:0] turn_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  owner_r;
  logic [N-1:0]      en_r;
  logic              busy_r;
  logic              turnaround_r;

  logic              pick_found_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              release_s;
  logic [IDX_W-1:0]  ptr_next_s;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N-1:0] one;
    one = N'(1);
    return one << i;
  endfunction

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Release conditions for the current owner; other indices are ignored.
  always_comb begin
    release_s  = done[owner_r] | ~req[owner_r] | (hold_r == HOLD_LIMIT);
    ptr_next_s = IDX_W'(wrap_add(int'(owner_r), 1, N));
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      hold_r       <= {HOLD_W{1'b0}};
      turn_r       <= {TURN_W{1'b0}};
      ptr_r        <= {IDX_W{1'b0}};
      owner_r      <= {IDX_W{1'b0}};
      en_r         <= {N{1'b0}};
      busy_r       <= 1'b0;
      turnaround_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            state_r <= ST_GRANT;
            owner_r <= pick_idx_s;
            en_r    <= onehot(pick_idx_s);
            busy_r  <= 1'b1;
            hold_r  <= HOLD_ONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            // Released owner moves to lowest priority for the next search.
            state_r      <= ST_TURN;
            en_r         <= {N{1'b0}};
            busy_r       <= 1'b0;
            hold_r       <= {HOLD_W{1'b0}};
            turn_r       <= TURN_ONE;
            turnaround_r <= 1'b1;
            ptr_r        <= ptr_next_s;
          end else begin
            hold_r <= hold_r + HOLD_ONE;
          end
        end
        ST_TURN: begin
          if (turn_r == TURN_LIMIT) begin
            turn_r       <= {TURN_W{1'b0}};
            turnaround_r <= 1'b0;
            if (pick_found_s) begin
              state_r <= ST_GRANT;
              owner_r <= pick_idx_s;
              en_r    <= onehot(pick_idx_s);
              busy_r  <= 1'b1;
              hold_r  <= HOLD_ONE;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            turn_r <= turn_r + TURN_ONE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          en_r         <= {N{1'b0}};
          busy_r       <= 1'b0;
          hold_r       <= {HOLD_W{1'b0}};
          turn_r       <= {TURN_W{1'b0}};
          turnaround_r <= 1'b0;
        end
      endcase
    end
  end

  assign en         = en_r;
  assign owner      = owner_r;
  assign busy       = busy_r;
  assign turnaround = turnaround_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: the driver steps a reference
// model on every clock edge and queues the expected outputs; a monitor on
// the falling edge pops and compares. A second instance built with
// MAX_HOLD=2, TURN_CYCLES=3 is checked against a fixed periodic pattern.
module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int TC = 1;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] own;
    logic       busy;
    logic       turn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] en;
  logic [1:0] owner;
  logic       busy;
  logic       turnaround;

  logic       rst2_n;
  logic [3:0] req2;
  logic [3:0] done2;
  logic [3:0] en2;
  logic [1:0] owner2;
  logic       busy2;
  logic       turn2;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];

  // reference model state
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_start = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .en(en), .owner(owner), .busy(busy), .turnaround(turnaround)
  );

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(2), .TURN_CYCLES(3)) u_dut2 (
    .clk(clk), .reset_n(rst2_n), .req(req2), .done(done2),
    .en(en2), .owner(owner2), .busy(busy2), .turnaround(turn2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_start = 0;
  endtask

  // One clock edge of the arbitration rules, then queue the expectation.
  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    bit   pick;
    pick = 1'b0;
    if (m_owner >= 0) begin
      if (d[m_owner] || !r[m_owner] || m_held == MH) begin
        m_start = (m_owner + 1) % N;
        m_owner = -1;
        m_held  = 0;
        m_gap   = TC;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      pick = (m_gap == 0);
    end else begin
      pick = 1'b1;
    end
    if (pick) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_start + k) % N]) begin
          m_owner = (m_start + k) % N;
          m_held  = 1;
        end
      end
    end
    e.en   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.own  = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
    e.busy = (m_owner >= 0);
    e.turn = (m_gap > 0);
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    done    = 4'b0000;
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_en", 32'(en), 32'h0);
    chk("reset_owner", 32'(owner), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_turn", 32'(turnaround), 32'h0);
    reset_n = 1'b1;
  endtask

  // Monitor: scoreboard compare plus per-cycle invariants.
  logic [3:0] last_nz = 4'b0000;
  int         zeros   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      last_nz = 4'b0000;
      zeros   = 0;
    end else begin
      chk("onehot_en", 32'($countones(en) <= 1), 32'h1);
      chk("busy_eq_or_en", 32'(busy), 32'(|en));
      if (en != 4'b0000) begin
        if (last_nz != 4'b0000 && en != last_nz) begin
          chk("turn_gap", 32'(zeros >= TC), 32'h1);
        end
        last_nz = en;
        zeros   = 0;
      end else begin
        zeros++;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_en", 32'(en), 32'(e.en));
        chk("sb_busy", 32'(busy), 32'(e.busy));
        chk("sb_turn", 32'(turnaround), 32'(e.turn));
        if (e.busy) begin
          chk("sb_owner", 32'(owner), 32'(e.own));
        end
      end
    end
  end

  initial begin
    logic [3:0] d;
    logic [3:0] rr;
    int         p;
    logic [3:0] exp2;

    reset_n = 1'b0;
    req     = 4'b0000;
    done    = 4'b0000;
    rst2_n  = 1'b0;
    req2    = 4'b0000;
    done2   = 4'b0000;
    @(posedge clk);
    #2;

    // sole requester: hold limit, one turnaround cycle, re-grant
    do_reset();
    for (int i = 0; i < 25; i++) cyc(4'b0100, 4'b0000);

    // all request: round-robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 45; i++) cyc(4'b1111, 4'b0000);

    // early release by owner 1 on its 3rd cycle, stray done[3]
    do_reset();
    for (int i = 0; i < 40; i++) begin
      d = 4'b0000;
      if (m_owner == 1 && m_held == 3) d[1] = 1'b1;
      if (i % 5 == 0) d[3] = 1'b1;
      cyc(4'b0011, d);
    end

    // owner drops request after 2 cycles, bus returns to idle
    do_reset();
    cyc(4'b0001, 4'b0000);
    cyc(4'b0001, 4'b0000);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 4'b0000);
    chk("idle_en", 32'(en), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_turn", 32'(turnaround), 32'h0);

    // asynchronous reset while owner 3 holds the bus
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'b1000, 4'b0000);
    chk("pre_reset_owner", 32'(owner), 32'h3);
    chk("pre_reset_en", 32'(en), 32'h8);
    reset_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("async_reset_en", 32'(en), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) cyc(4'b1001, 4'b0000);

    // randomized requests and done pulses
    do_reset();
    rr = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) rr = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cyc(rr, d);
    end
    cyc(4'b0000, 4'b0000);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    // MAX_HOLD=2, TURN_CYCLES=3 instance: 2 x 0001, 3 x 0, 2 x 0010, 3 x 0
    req2   = 4'b0011;
    rst2_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #2;
      p = (e - 1) % 10;
      exp2 = (p < 2) ? 4'b0001 : ((p == 5 || p == 6) ? 4'b0010 : 4'b0000);
      chk("short_hold_pattern", 32'(en2), 32'(exp2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Upstream control stage for shared tristate buses: decides which of N drivers owns the bus and produces their one-hot output-enable lines.
- Each en[i] feeds the enable input of a 4-bit tristate driver; all drivers tie to one tri net.
- Uses round-robin fairness, a hold limit per ownership, and mandatory all-off turnaround cycles between owners, so two drivers never drive the net at once and the net floats (z) only in idle or turnaround.

Parameters:
- N, 4, number of requesting drivers (2..16)
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the bus (1..255)
- TURN_CYCLES, 1, all-enables-off cycles between any release and the next grant (1..7)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  N  per-driver bus request, level
- done  input  N  per-driver early release, single-cycle pulse, honoured only from current owner
- en  output  N  one-hot-or-zero enable to tristate drivers, registered
- owner  output  $clog2(N)  index of current owner; valid only while busy=1
- busy  output  1  high while any en bit is high
- turnaround  output  1  high during the all-off gap cycles

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n). Assert: en=0, owner=0, busy=0, turnaround=0, state=IDLE, hold count=0, round-robin pointer so first search starts at index 0. Deassertion is synchronous to clk.
- All outputs come from registers; no combinational path from req/done to en.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If any req bit is sampled high at edge k: GRANT, with en[sel]=1 visible after edge k (1-cycle latency).
  - sel = first set req bit searching upward from pointer, wrapping N-1 -> 0.
- GRANT:
  - Hold counter starts at 1 on the grant edge and increments each edge.
  - Release at the edge where any of these holds: done[owner]=1, req[owner]=0, or hold count = MAX_HOLD.
  - Release gives en=0 and enters TURN. Pointer = owner+1 mod N.
  - done/req on non-owner indices are ignored.
- TURN:
  - turnaround=1 for exactly TURN_CYCLES cycles.
  - At the final TURN edge, arbitrate with the same rule as IDLE. Any req -> GRANT directly; none -> IDLE.
  - A requester that just released may be re-granted only if no other req is set (fairness).
- Invariants:
  - popcount(en) <= 1 every cycle.
  - en never changes from one nonzero value to a different nonzero value without at least TURN_CYCLES zero cycles between.
  - busy == |en.
- Simultaneous events: done and hold expiry on the same edge count as one release. req rising during TURN is eligible at the final TURN edge.
- Reset mid-operation: en drops to 0 asynchronously, with no glitch to another owner. Arbitration restarts from index 0.
- Counter width: $clog2(MAX_HOLD+1). Turn counter width: $clog2(TURN_CYCLES+1). No overflow permitted.

Decomposition:
- Package tristate_bus_pkg:
  - state enum typedef (IDLE, GRANT, TURN)
  - default WIDTH=4 bus width constant, shared with the tristate driver instances
- One sub-module: rr_pick.
  - Combinational round-robin priority select.
  - Inputs: req vector and pointer. Outputs: found flag and index.

Test Plan:
- Reset, then req=4'b0100 held -> en=4'b0100 one cycle after first sampled edge; owner=2; busy=1; released at hold count 8. TURN_CYCLES=1 gives en=0 for 1 cycle, then en=4'b0100 again (sole requester).
- req=4'b1111 held continuously -> grant order 0,1,2,3,0. Each ownership lasts 8 cycles with exactly 1 turnaround cycle between; popcount(en)<=1 checked every cycle.
- Owner 1 pulses done[1] on its 3rd cycle while req=4'b0011 -> en=0 next cycle, then owner 0 granted. A done[3] pulse from a non-owner causes no change.
- Owner drops req after 2 cycles with no other requests -> TURN for TURN_CYCLES cycles, then IDLE with en=0 and busy=0; tri net observed as 4'bzzzz.
- reset_n asserted mid-GRANT with owner=3 -> en=0 immediately, before the next clk edge. After release with req=4'b1001, owner=0 is granted first.
- TURN_CYCLES=3, MAX_HOLD=2 build: req=4'b0011 -> pattern 2 cycles en=0001, 3 cycles zero, 2 cycles en=0010, repeating.
